// File: rtl/game_viewport_timing.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// game_viewport_timing
//
// Generates 800x600@60 Hz VGA raster timing and maps the physical raster onto
// an integer-upscaled GAME_W x GAME_H game viewport. Every output is registered
// one cycle after the raster counter state it describes, so all outputs are
// mutually aligned.
//
// Configuration macro: VIEWPORT_CENTER_EN
//   defined   -> viewport centred in the active area
//   undefined -> viewport anchored at the top-left corner
//
// Ports:
//   vga_pix_clk      in   pixel clock
//   rst              in   synchronous, active-high reset
//   hsync, vsync     out  monitor sync pins, active-high
//   vga_de           out  physical active video area
//   display_enabled  out  beam inside the game viewport
//   sx, sy           out  game pixel coordinates (0 outside the viewport)
//   game_pix_stb     out  first physical pixel of each game pixel
//   frame_stb        out  one-cycle pulse at viewport pixel (0,0)
// -----------------------------------------------------------------------------
module game_viewport_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int GAME_W   = 224,
  parameter int GAME_H   = 288,
  parameter int SCALE    = 2
) (
  input  logic                      vga_pix_clk,
  input  logic                      rst,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      vga_de,
  output logic                      display_enabled,
  output logic [$clog2(GAME_W)-1:0] sx,
  output logic [$clog2(GAME_H)-1:0] sy,
  output logic                      game_pix_stb,
  output logic                      frame_stb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int VP_W    = GAME_W * SCALE;
  localparam int VP_H    = GAME_H * SCALE;
`ifdef VIEWPORT_CENTER_EN
  localparam int X0 = (H_ACTIVE - VP_W) / 2;
  localparam int Y0 = (V_ACTIVE - VP_H) / 2;
`else
  localparam int X0 = 0;
  localparam int Y0 = 0;
`endif

  localparam int HW   = $clog2(H_TOTAL);
  localparam int VW   = $clog2(V_TOTAL);
  localparam int SUBW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int SXW  = $clog2(GAME_W);
  localparam int SYW  = $clog2(GAME_H);

  // Width-matched constants for every comparison against the counters.
  localparam logic [HW-1:0]   HC_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]   HC_X0    = HW'(X0);
  localparam logic [HW-1:0]   HC_VPW   = HW'(VP_W);
  localparam logic [HW-1:0]   HC_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0]   HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]   HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]   VC_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]   VC_Y0    = VW'(Y0);
  localparam logic [VW-1:0]   VC_VPH   = VW'(VP_H);
  localparam logic [VW-1:0]   VC_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0]   VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]   VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SUBW-1:0] SUB_LAST = SUBW'(SCALE - 1);

  if (VP_W > H_ACTIVE || VP_H > V_ACTIVE) begin : g_vp_too_big
    $error("game_viewport_timing: scaled viewport does not fit the active area");
  end

  logic [HW-1:0]   hc, hc_nxt, hx;
  logic [VW-1:0]   vc, vc_nxt, vy;
  logic [SUBW-1:0] subx, suby;
  logic [SXW-1:0]  sx_cnt;
  logic [SYW-1:0]  sy_cnt;
  logic            h_wrap, in_h, in_v, in_vp;

  // Offsets from the viewport origin; below the origin they wrap to large
  // values, so a single unsigned compare covers both viewport edges.
  assign hx     = hc - HC_X0;
  assign vy     = vc - VC_Y0;
  assign in_h   = hx < HC_VPW;
  assign in_v   = vy < VC_VPH;
  assign in_vp  = in_h && in_v;
  assign h_wrap = (hc == HC_LAST);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    hc_nxt = h_wrap ? '0 : hc + 1'b1;
    vc_nxt = vc;
    if (h_wrap) vc_nxt = (vc == VC_LAST) ? '0 : vc + 1'b1;
  end

  // Raster and sub-pixel counters. The sub-counters hold the values that
  // belong to the current (hc, vc), so they are cleared on the edge that
  // moves the beam onto the viewport origin column/row.
  always_ff @(posedge vga_pix_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      hc     <= '0;
      vc     <= '0;
      subx   <= '0;
      sx_cnt <= '0;
      suby   <= '0;
      sy_cnt <= '0;
    end else begin
      hc <= hc_nxt;
      vc <= vc_nxt;

      if (hc_nxt == HC_X0) begin
        subx   <= '0;
        sx_cnt <= '0;
      end else if (in_vp) begin
        if (subx == SUB_LAST) begin
          subx   <= '0;
          sx_cnt <= sx_cnt + 1'b1;
        end else begin
          subx <= subx + 1'b1;
        end
      end

      if (h_wrap) begin
        if (vc_nxt == VC_Y0) begin
          suby   <= '0;
          sy_cnt <= '0;
        end else if (in_v) begin
          if (suby == SUB_LAST) begin
            suby   <= '0;
            sy_cnt <= sy_cnt + 1'b1;
          end else begin
            suby <= suby + 1'b1;
          end
        end
      end
    end
  end

  // Output register stage: one cycle behind the counters, all outputs aligned.
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      hsync           <= 1'b0;
      vsync           <= 1'b0;
      vga_de          <= 1'b0;
      display_enabled <= 1'b0;
      sx              <= '0;
      sy              <= '0;
      game_pix_stb    <= 1'b0;
      frame_stb       <= 1'b0;
    end else begin
      hsync           <= (hc >= HS_BEG) && (hc < HS_END);
      vsync           <= (vc >= VS_BEG) && (vc < VS_END);
      vga_de          <= (hc < HC_ACT) && (vc < VC_ACT);
      display_enabled <= in_vp;
      sx              <= in_vp ? sx_cnt : '0;
      sy              <= in_vp ? sy_cnt : '0;
      game_pix_stb    <= in_vp && (subx == '0) && (suby == '0);
      frame_stb       <= in_vp && (subx == '0) && (suby == '0) &&
                         (sx_cnt == '0) && (sy_cnt == '0);
    end
  end

endmodule

// File: doc/game_viewport_timing.md
# game_viewport_timing

- Generates 800x600@60 Hz VGA timing from `vga_pix_clk`.
- Maps the physical raster onto the 224x288 game viewport, integer-upscaled by SCALE.
- Produces the registered beam coordinates and strobes that the game/draw stage consumes (`sx`, `sy`, `game_pix_stb`, `frame_stb`, `display_enabled`), plus the monitor sync pins.
- It sits directly upstream of the game stage, which adds its own one-cycle pipeline.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40; H_SYNC, 128; H_BP, 88 — horizontal porches/sync, in pixels
- V_ACTIVE, 600, visible lines
- V_FP, 1; V_SYNC, 4; V_BP, 23 — vertical porches/sync, in lines
- GAME_W, 224; GAME_H, 288 — game viewport size, in game pixels
- SCALE, 2 — physical pixels per game pixel, on each axis

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - vga_pix_clk  in  1  pixel clock, 40 MHz
  - rst  in  1  synchronous, active-high reset
- hsync  out  1  horizontal sync, active-high
- vsync  out  1  vertical sync, active-high
- vga_de  out  1  physical active video area
- display_enabled  out  1  beam is inside the game viewport
- sx  out  $clog2(GAME_W)=8  game x, range 0..223
- sy  out  $clog2(GAME_H)=9  game y, range 0..287
- game_pix_stb  out  1  first physical pixel of each game pixel
- frame_stb  out  1  one-cycle pulse at viewport pixel (0,0)

## Operation
Counters:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 1056.
- V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP = 628.
- `hc` counts 0..H_TOTAL-1 and wraps to 0.
- `vc` increments when `hc` wraps; it wraps to 0 after V_TOTAL-1.

Raster regions:
- Active area: `hc` < H_ACTIVE and `vc` < V_ACTIVE.
- hsync is 1 for H_ACTIVE+H_FP ≤ `hc` < H_ACTIVE+H_FP+H_SYNC, i.e. 840..967.
- vsync is 1 for `vc` in 601..604.

Viewport:
- Origin (X0, Y0); size GAME_W·SCALE × GAME_H·SCALE = 448×576.
- `in_vp` = X0 ≤ `hc` < X0+448 and Y0 ≤ `vc` < Y0+576.

Sub-pixel counters:
- `subx` counts 0..SCALE-1 across `in_vp` pixels.
- `sx` increments when `subx` wraps.
- Both `subx` and `sx` are cleared at every `hc` == X0.
- `suby` and `sy` advance the same way, per line, at `hc` == H_TOTAL-1 for lines inside the viewport; both are cleared at `vc` == Y0.

Outputs:
- `game_pix_stb` = `in_vp` & `subx`==0 & `suby`==0.
- `frame_stb` = `in_vp` & `sx`==0 & `sy`==0 & `subx`==0 & `suby`==0. It fires exactly once per frame.
- Outside the viewport: `sx` = 0, `sy` = 0, `display_enabled` = 0, and both strobes = 0.

Arithmetic:
- All counters are unsigned.
- There is no saturation; wrap occurs only at the bounds stated above.

Elaboration check:
- GAME_W·SCALE must be ≤ H_ACTIVE and GAME_H·SCALE must be ≤ V_ACTIVE.
- Otherwise `$error` is raised at elaboration.

## Timing
- Every output is registered, and all outputs are mutually aligned.
  - Outputs at cycle n+1 reflect the counter state at cycle n.
  - Latency is therefore 1 cycle, for every output.
- Reset behaviour:
  - Asserting `rst` at any cycle takes effect on the next edge, even mid-frame or mid-sync.
  - That edge sets `hc`=`vc`=0 and clears all sub-counters.
  - It also forces `hsync`=`vsync`=`vga_de`=`display_enabled`=`game_pix_stb`=`frame_stb`=0 and `sx`=`sy`=0.
  - In the first cycle after `rst` deasserts, the counters are at (0,0).
  - Outputs at (0,0) appear one cycle later.
- Frame period is 1056·628 = 663168 cycles.
- `frame_stb` precedes any game-pixel update on its frame's first visible line. The game stage updates sprite positions on it.

## Configuration
- `VIEWPORT_CENTER_EN`
  - Defined: X0 = (H_ACTIVE − GAME_W·SCALE)/2 = 176 and Y0 = (V_ACTIVE − GAME_H·SCALE)/2 = 12. The viewport is centred.
  - Undefined: X0 = Y0 = 0. The viewport is top-left aligned.
- The macro changes only the constants X0 and Y0. All other behaviour is identical.

## Test plan
- Reset, then run 2 full frames.
  - Required: hsync pulse width = 128 cycles, period = 1056 cycles.
  - Required: vsync high for 4 lines (4224 cycles).
  - Required: exactly one `frame_stb` per 663168 cycles.
- `VIEWPORT_CENTER_EN` defined:
  - First `display_enabled`=1 occurs at `hc`=176, `vc`=12 (observed one cycle later), with `sx`=0 and `sy`=0.
  - `frame_stb`=1 on that same cycle.
  - Last in-viewport pixel is `hc`=623, `vc`=587, with `sx`=223 and `sy`=287.
- `VIEWPORT_CENTER_EN` undefined:
  - `frame_stb` occurs 1 cycle after (`hc`,`vc`) = (0,0).
  - `display_enabled` deasserts at `hc`=448.
- Within one viewport line:
  - `sx` sequence is 0,0,1,1,…,223,223.
  - `game_pix_stb` pulses on every 2nd cycle on even viewport lines (`suby`=0): 224 pulses on those lines, 0 on odd lines.
  - `sy` increments every 2 lines.
- Assert `rst` for 1 cycle at `hc`=900, `vc`=300 (mid-hsync).
  - Required: next cycle hsync=0 and `display_enabled`=0.
  - Required: counters restart at (0,0), and the next `frame_stb` arrives at the correct offset from restart.
- Scoreboard check over 3 frames: count `game_pix_stb` pulses = 224·288 = 64512 per frame, and count `vga_de` cycles = 480000 per frame.
